// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-to-RAM command path.
// Holds the frame FSM states, the RAM command codes and the default bus widths.
package spi_ram_pkg;

  localparam int DEF_RX_WIDTH = 10;
  localparam int DEF_TX_WIDTH = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

endpackage

// File: rtl/spi_tx_shifter.sv
// Loads RAM read data in parallel and shifts it out MSB-first, one bit per clk.
// Latency: MSB on the output the cycle after load; no backpressure, clr aborts at once.
module spi_tx_shifter #(
  parameter int TX_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                load,
  input  logic [TX_WIDTH-1:0] din,
  output logic                bit_out,
  output logic                busy,
  output logic                last,
  output logic                done
);

  localparam int CW = $clog2(TX_WIDTH) + 1;

  logic [TX_WIDTH-1:0] sh;
  logic [CW-1:0]       cnt;

  // The MSB goes straight to bit_out on load, so sh holds only the bits still to send.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '0;
      cnt     <= '0;
      bit_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (clr) begin
      sh      <= '0;
      cnt     <= '0;
      bit_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (load) begin
      sh      <= {din[TX_WIDTH-2:0], 1'b0};
      cnt     <= CW'(TX_WIDTH - 1);
      bit_out <= din[TX_WIDTH-1];
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (busy) begin
      if (cnt != '0) begin
        bit_out <= sh[TX_WIDTH-1];
        sh      <= {sh[TX_WIDTH-2:0], 1'b0};
        cnt     <= cnt - CW'(1);
      end else begin
        bit_out <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

  assign last = busy && (cnt == '0);

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI into RAM commands, serialises read data on MISO.
// Latency: rx_valid the cycle after the last command bit; no backpressure, every clk is a bit.
module spi_slave_if
  import spi_ram_pkg::*;
#(
  parameter int RX_WIDTH = DEF_RX_WIDTH,
  parameter int TX_WIDTH = DEF_TX_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_valid
);

  localparam int                CNT_W     = $clog2(RX_WIDTH) + 1;
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(RX_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(RX_WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             rd_addr_done;

  logic abort;
  logic tx_load;
  logic tx_bit;
  logic tx_busy;
  logic tx_last;
  logic tx_done;
  logic tx_latched;

  assign abort      = SS_n && (state != IDLE);
  assign tx_latched = tx_busy || tx_done;

  // WAIT_TX opens only after the rx_valid cycle, and closes for good once data is latched.
  assign tx_load = (state == READ_DATA) && !SS_n && (bit_cnt == FRAME_LEN) &&
                   !rx_valid && !tx_latched && tx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rd_addr_done <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        bit_cnt <= '0;
        if (tx_latched) begin
          rd_addr_done <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (!SS_n) begin
              state <= CHK_CMD;
            end
          end
          CHK_CMD: begin
            if (!MOSI) begin
              state <= WRITE;
            end else if (rd_addr_done) begin
              state <= READ_DATA;
            end else begin
              state <= READ_ADD;
            end
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt < FRAME_LEN) begin
              rx_data <= {rx_data[RX_WIDTH-2:0], MOSI};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                rx_valid <= 1'b1;
                if (state == READ_ADD) begin
                  rd_addr_done <= 1'b1;
                end
              end
            end
            if (tx_last) begin
              rd_addr_done <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  spi_tx_shifter #(
    .TX_WIDTH (TX_WIDTH)
  ) u_tx_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (abort),
    .load    (tx_load),
    .din     (tx_data),
    .bit_out (tx_bit),
    .busy    (tx_busy),
    .last    (tx_last),
    .done    (tx_done)
  );

  assign MISO = tx_bit;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write, read, abort, async reset and held tx_valid.
module tb_spi_slave_if;
  import spi_ram_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_cmp;
  int n_err;

  spi_slave_if #(
    .RX_WIDTH (10),
    .TX_WIDTH (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves SS_n low, one edge past the rx_valid cycle.
  task automatic frame(input logic sel, input logic [9:0] w);
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick;
    chk("enter_chk_cmd", 32'(dut.state), 32'(CHK_CMD));
    MOSI = sel;
    tick;
    for (int i = 9; i >= 0; i--) begin
      MOSI = w[i];
      tick;
      chk("rx_valid_bit", 32'(rx_valid), 32'(i == 0));
      chk("miso_cmd", 32'(MISO), 32'd0);
    end
    chk("rx_data", 32'(rx_data), 32'(w));
    MOSI = 1'b0;
    tick;
    chk("rx_valid_drop", 32'(rx_valid), 32'd0);
  endtask

  task automatic end_frame;
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick;
    chk("idle_after_ss", 32'(dut.state), 32'(IDLE));
    chk("cnt_after_ss", 32'(dut.bit_cnt), 32'd0);
    chk("miso_after_ss", 32'(MISO), 32'd0);
    chk("rx_valid_after_ss", 32'(rx_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] pat;
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b1;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_rd_addr_done", 32'(dut.rd_addr_done), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("idle_after_rst", 32'(dut.state), 32'(IDLE));

    // Write address then write data.
    frame(1'b0, 10'h0A5);
    end_frame;
    frame(1'b0, 10'h13C);
    end_frame;

    // Read address frame sets rd_addr_done, which survives SS_n going high.
    frame(1'b1, 10'h2A5);
    chk("rd_addr_done_set", 32'(dut.rd_addr_done), 32'd1);
    end_frame;
    chk("rd_addr_done_kept", 32'(dut.rd_addr_done), 32'd1);

    // Read data frame, RAM answers one cycle after rx_valid with 8'hC3.
    frame(1'b1, {CMD_RD_DATA, 8'h00});
    chk("state_read_data", 32'(dut.state), 32'(READ_DATA));
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    pat = 8'hC3;
    for (int k = 7; k >= 0; k--) begin
      tick;
      tx_valid = 1'b0;
      chk("miso_c3", 32'(MISO), 32'(pat[k]));
    end
    tick;
    chk("miso_after_c3", 32'(MISO), 32'd0);
    chk("rd_addr_done_clr", 32'(dut.rd_addr_done), 32'd0);
    tick;
    chk("miso_idle_tail", 32'(MISO), 32'd0);
    end_frame;

    // Abort after 5 command bits: no strobe, back to IDLE with counter cleared.
    SS_n = 1'b0;
    tick;
    MOSI = 1'b0;
    tick;
    pat = 8'b10110000;
    for (int k = 7; k >= 3; k--) begin
      MOSI = pat[k];
      tick;
      chk("abort_no_vld", 32'(rx_valid), 32'd0);
    end
    chk("abort_cnt_mid", 32'(dut.bit_cnt), 32'd5);
    end_frame;
    tick;
    chk("abort_no_vld_late", 32'(rx_valid), 32'd0);
    frame(1'b0, 10'h007);
    end_frame;

    // Held tx_valid: latched once, later tx_data change does not reach MISO.
    frame(1'b1, {CMD_RD_ADDR, 8'h11});
    end_frame;
    frame(1'b1, {CMD_RD_DATA, 8'h00});
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    pat = 8'h5A;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (c == 3) tx_data = 8'hFF;
      chk("miso_held", 32'(MISO), (c < 8) ? 32'(pat[7-c]) : 32'd0);
    end
    tx_valid = 1'b0;
    chk("held_rd_addr_done", 32'(dut.rd_addr_done), 32'd0);
    end_frame;

    // Async reset in the middle of a READ_DATA shift.
    frame(1'b1, {CMD_RD_ADDR, 8'h33});
    end_frame;
    frame(1'b1, {CMD_RD_DATA, 8'h00});
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    chk("pre_rst_miso0", 32'(MISO), 32'd1);
    tick;
    chk("pre_rst_miso1", 32'(MISO), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_miso", 32'(MISO), 32'd0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    chk("mid_rst_rd_addr_done", 32'(dut.rd_addr_done), 32'd0);
    tick;
    rst_n = 1'b1;
    SS_n  = 1'b1;
    tick;
    chk("post_rst_idle", 32'(dut.state), 32'(IDLE));
    chk("post_rst_miso", 32'(MISO), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
